// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the memory stage.
//   OP_LW / OP_SW      : major opcodes in insn[31:27]
//   EXC_DMEM_TIMEOUT   : exception code written to mw_o on a dmem abort
//   mem_state_e        : memory-stage request FSM states
//   stage_t            : one pipeline latch entry (XM and MW share the layout)
package pipeline_pkg;

  localparam logic [4:0]  OP_LW            = 5'b01000;
  localparam logic [4:0]  OP_SW            = 5'b00111;
  localparam logic [31:0] EXC_DMEM_TIMEOUT = 32'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // XM: data = store data (b_out). MW: data = load data (d).
  typedef struct packed {
    logic        valid;
    logic [31:0] insn;
    logic [31:0] o;
    logic [31:0] data;
    logic        exc;
  } stage_t;

  function automatic logic [4:0] opcode(input logic [31:0] insn);
    return insn[31:27];
  endfunction

endpackage

// File: rtl/stage_memory_pipe_latch.sv
// pipe_latch: generic pipeline register with hold and synchronous clear.
//   clock, reset (async, active-low)
//   en  : capture d on the rising edge
//   clr : load zero on the rising edge (wins over en); used to insert bubbles
//   d/q : W-bit payload
module pipe_latch #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/stage_memory.sv
// stage_memory: pipeline memory stage (XM latch, dmem handshake, MW latch).
//   clock, reset (async, active-low)
//   x_*            : execute results entering the XM latch
//   wm_bypass_B    : use data_writeReg as store data instead of latched b_out
//   stall_out      : freezes execute and upstream while a dmem access waits
//   o_xm_out       : latched result for the MX bypass; xm_insn for hazards
//   dmem_*         : data-memory request/ack interface
//   mw_*           : MW latch outputs to writeback
// Optional feature: define XM_EXCEPTION_EN to propagate x_exception and to
// flag a dmem timeout abort (mw_exception=1, mw_o=EXC_DMEM_TIMEOUT).
module stage_memory
  import pipeline_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DMEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              x_valid,
  input  logic [31:0]       x_insn,
  input  logic [31:0]       x_o_out,
  input  logic [31:0]       x_b_out,
  input  logic              x_exception,
  input  logic              wm_bypass_B,
  input  logic [31:0]       data_writeReg,
  output logic              stall_out,
  output logic [31:0]       o_xm_out,
  output logic [31:0]       xm_insn,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mw_valid,
  output logic [31:0]       mw_insn,
  output logic [31:0]       mw_o,
  output logic [31:0]       mw_d,
  output logic              mw_exception
);

  localparam logic [3:0] TMO = 4'(DMEM_TIMEOUT);

  stage_t     xm_in, xm, mw_in, mw;
  mem_state_e state, state_n;
  logic [3:0] wait_cnt;
  logic       is_lw, is_sw, mem_op, timeout, tmo_abort;

  // ---------------- XM latch: frozen while the stage stalls
  assign xm_in = '{valid: x_valid, insn: x_insn, o: x_o_out,
                   data: x_b_out, exc: x_exception};

  pipe_latch #(.W($bits(stage_t))) u_xm (
    .clock (clock),
    .reset (reset),
    .en    (~stall_out),
    .clr   (1'b0),
    .d     (xm_in),
    .q     (xm)
  );

  // ---------------- decode / handshake
  assign is_lw   = (opcode(xm.insn) == OP_LW);
  assign is_sw   = (opcode(xm.insn) == OP_SW);
  assign mem_op  = xm.valid & (is_lw | is_sw);

  assign timeout   = (state == ST_WAIT) & (wait_cnt == TMO);
  // Ack arriving on the timeout cycle is a normal completion.
  assign tmo_abort = timeout & ~dmem_ack;

  // A mem-op sits in XM only until it completes (XM reloads on that edge),
  // so "latched mem-op" is the same as "not yet completed".
  assign dmem_req  = mem_op & ~tmo_abort;
  assign dmem_we   = dmem_req & is_sw;
  assign stall_out = mem_op & ~dmem_ack & ~timeout;
  assign dmem_addr = xm.o[ADDR_W-1:0];
  // Gated by reset so every output reads zero while reset is held.
  assign dmem_wdata = (wm_bypass_B && reset) ? data_writeReg : xm.data;

  // ---------------- FSM + wait counter
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (mem_op && !dmem_ack)  state_n = ST_WAIT;
      ST_WAIT: if (dmem_ack || timeout)  state_n = ST_IDLE;
      default:                           state_n = ST_IDLE;
    endcase
  end

  // The counter also steps on the entering cycle, so the IDLE cycle that
  // first raises the request is counted as one of the DMEM_TIMEOUT stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= (state_n == ST_WAIT) ? wait_cnt + 4'd1 : 4'd0;
    end
  end

  // ---------------- MW latch: loads every edge, bubble while stalled
  always_comb begin
    mw_in      = xm;
    mw_in.data = (mem_op && is_lw && dmem_ack) ? dmem_rdata : 32'd0;
`ifdef XM_EXCEPTION_EN
    if (tmo_abort) begin
      mw_in.exc = 1'b1;
      mw_in.o   = EXC_DMEM_TIMEOUT;
    end
`else
    mw_in.exc = 1'b0;
`endif
  end

  pipe_latch #(.W($bits(stage_t))) u_mw (
    .clock (clock),
    .reset (reset),
    .en    (1'b1),
    .clr   (stall_out),
    .d     (mw_in),
    .q     (mw)
  );

  assign o_xm_out = xm.o;
  assign xm_insn  = xm.insn;
  assign mw_valid = mw.valid;
  assign mw_insn  = mw.insn;
  assign mw_o     = mw.o;
  assign mw_d     = mw.data;
`ifdef XM_EXCEPTION_EN
  assign mw_exception = mw.exc;
`else
  assign mw_exception = 1'b0;
  logic unused_exc;
  assign unused_exc = xm.exc ^ mw.exc;
`endif

endmodule

// File: tb/tb_stage_memory.sv
module tb_stage_memory;

  localparam int ADDR_W = 12;
  localparam logic [31:0] I_ADD = 32'h00A0_0000;
  localparam logic [31:0] I_LW  = 32'h4000_0000;
  localparam logic [31:0] I_SW  = 32'h3800_0000;

`ifdef XM_EXCEPTION_EN
  localparam logic        EXC_ON = 1'b1;
`else
  localparam logic        EXC_ON = 1'b0;
`endif

  logic              clock = 1'b0, reset;
  logic              x_valid, x_exception, wm_bypass_B;
  logic [31:0]       x_insn, x_o_out, x_b_out, data_writeReg;
  logic              stall_out, dmem_req, dmem_we, dmem_ack;
  logic [31:0]       o_xm_out, xm_insn, dmem_wdata, dmem_rdata;
  logic [ADDR_W-1:0] dmem_addr;
  logic              mw_valid, mw_exception;
  logic [31:0]       mw_insn, mw_o, mw_d;

  int checks = 0, failures = 0;
  int nstall;

  always #5 clock = ~clock;

  stage_memory #(.ADDR_W(ADDR_W), .DMEM_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .x_valid(x_valid), .x_insn(x_insn), .x_o_out(x_o_out),
    .x_b_out(x_b_out), .x_exception(x_exception),
    .wm_bypass_B(wm_bypass_B), .data_writeReg(data_writeReg),
    .stall_out(stall_out), .o_xm_out(o_xm_out), .xm_insn(xm_insn),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mw_valid(mw_valid), .mw_insn(mw_insn), .mw_o(mw_o), .mw_d(mw_d),
    .mw_exception(mw_exception)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1, checks run at posedge+3.
  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] o,
                       input logic [31:0] b, input logic exc);
    x_valid = v; x_insn = insn; x_o_out = o; x_b_out = b; x_exception = exc;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, I_LW, 32'h104, 32'h55, 1'b1);
    wm_bypass_B = 1'b1; data_writeReg = 32'hCAFE_0001;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;

    // ---- reset state: everything zero regardless of inputs
    tick; tick; #2;
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_req",   {31'd0, dmem_req},  32'd0);
    chk("rst_we",    {31'd0, dmem_we},   32'd0);
    chk("rst_addr",  {20'd0, dmem_addr}, 32'd0);
    chk("rst_wdata", dmem_wdata,         32'd0);
    chk("rst_xm_o",  o_xm_out,           32'd0);
    chk("rst_xm_i",  xm_insn,            32'd0);
    chk("rst_mw_v",  {31'd0, mw_valid},  32'd0);
    chk("rst_mw_i",  mw_insn,            32'd0);
    chk("rst_mw_exc",{31'd0, mw_exception}, 32'd0);
    wm_bypass_B = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1;

    // ---- add: one cycle XM, next cycle MW, no stall
    tick; drive(1'b1, I_ADD, 32'h5, 32'h0, 1'b0);
    tick; drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); #2;
    chk("add_xm_o",  o_xm_out, 32'h5);
    chk("add_stall", {31'd0, stall_out}, 32'd0);
    chk("add_req",   {31'd0, dmem_req},  32'd0);
    tick; #2;
    chk("add_mw_v",  {31'd0, mw_valid}, 32'd1);
    chk("add_mw_i",  mw_insn, I_ADD);
    chk("add_mw_o",  mw_o,    32'h5);
    chk("add_mw_d",  mw_d,    32'h0);

    // ---- invalid lw never requests
    drive(1'b0, I_LW, 32'h104, 32'h0, 1'b0);
    tick; #2;
    chk("inv_req",   {31'd0, dmem_req},  32'd0);
    chk("inv_stall", {31'd0, stall_out}, 32'd0);

    // ---- lw, ack after 3 cycles; an add waits on x_* meanwhile
    drive(1'b1, I_LW, 32'h104, 32'h0, 1'b0);
    tick; drive(1'b1, I_ADD, 32'h7, 32'h0, 1'b0); #2;
    chk("lw_req",  {31'd0, dmem_req}, 32'd1);
    chk("lw_we",   {31'd0, dmem_we},  32'd0);
    chk("lw_addr", {20'd0, dmem_addr}, 32'h104);
    nstall = 0;
    for (int c = 0; c < 3; c++) begin
      if (stall_out) nstall++;
      if (c > 0) chk("lw_bubble", {31'd0, mw_valid}, 32'd0);
      chk("lw_frozen", xm_insn, I_LW);
      tick; #2;
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678; #1;
    chk("lw_ack_stall", {31'd0, stall_out}, 32'd0);
    chk("lw_nstall", nstall, 32'd3);
    chk("lw_bubble3", {31'd0, mw_valid}, 32'd0);
    tick; dmem_ack = 1'b0; drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); #2;
    chk("lw_mw_v", {31'd0, mw_valid}, 32'd1);
    chk("lw_mw_i", mw_insn, I_LW);
    chk("lw_mw_o", mw_o,    32'h104);
    chk("lw_mw_d", mw_d,    32'h1234_5678);
    chk("lw_next_xm", o_xm_out, 32'h7);
    tick; #2;
    chk("lw_next_mw", mw_o, 32'h7);

    // ---- sw with writeback bypass and zero-wait ack
    drive(1'b1, I_SW, 32'h20, 32'h1111, 1'b0);
    wm_bypass_B = 1'b1; data_writeReg = 32'hDEAD_BEEF;
    tick; drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); dmem_ack = 1'b1; #2;
    chk("sw_we",    {31'd0, dmem_we},   32'd1);
    chk("sw_wdata", dmem_wdata,         32'hDEAD_BEEF);
    chk("sw_addr",  {20'd0, dmem_addr}, 32'h20);
    chk("sw_stall", {31'd0, stall_out}, 32'd0);
    wm_bypass_B = 1'b0; #1;
    chk("sw_wdata_nb", dmem_wdata, 32'h1111);
    tick; dmem_ack = 1'b0; #2;
    chk("sw_mw_i", mw_insn, I_SW);
    chk("sw_mw_d", mw_d,    32'h0);

    // ---- lw with no ack: 15 stall cycles then timeout completion
    drive(1'b1, I_LW, 32'h3FC, 32'h0, 1'b0);
    tick; drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); #2;
    nstall = 0;
    for (int c = 0; c < 40; c++) begin
      if (!stall_out) break;
      nstall++;
      tick; #2;
    end
    chk("tmo_nstall", nstall, 32'd15);
    chk("tmo_req",    {31'd0, dmem_req}, 32'd0);
    tick; #2;
    chk("tmo_mw_v",   {31'd0, mw_valid}, 32'd1);
    chk("tmo_mw_i",   mw_insn, I_LW);
    chk("tmo_mw_d",   mw_d,    32'h0);
    chk("tmo_mw_exc", {31'd0, mw_exception}, {31'd0, EXC_ON});
    chk("tmo_mw_o",   mw_o, EXC_ON ? 32'd6 : 32'h3FC);
    chk("tmo_stall",  {31'd0, stall_out}, 32'd0);

    // ---- reset while in WAIT
    drive(1'b1, I_LW, 32'h44, 32'h0, 1'b0);
    tick; drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick; #2;
    chk("rw_stall_pre", {31'd0, stall_out}, 32'd1);
    reset = 1'b0; #1;
    chk("rw_req",   {31'd0, dmem_req},  32'd0);
    chk("rw_mw_v",  {31'd0, mw_valid},  32'd0);
    chk("rw_stall", {31'd0, stall_out}, 32'd0);
    tick; reset = 1'b1;
    tick; #2;
    chk("rw_no_cmp", {31'd0, mw_valid}, 32'd0);
    chk("rw_req2",   {31'd0, dmem_req}, 32'd0);
    drive(1'b1, I_ADD, 32'h9, 32'h0, 1'b1);
    tick; drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0); #2;
    chk("rw_add_xm", o_xm_out, 32'h9);
    tick; #2;
    chk("rw_add_mw_v", {31'd0, mw_valid}, 32'd1);
    chk("rw_add_mw_o", mw_o, 32'h9);
    chk("rw_add_exc",  {31'd0, mw_exception}, {31'd0, EXC_ON});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 Parameter ADDR_W, default 12, number of dmem word-address bits taken from o_out[ADDR_W-1:0].
REQ-002 Parameter DMEM_TIMEOUT, default 15, wait cycles before an unacknowledged dmem request aborts.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; clears all state immediately, independent of clock.
REQ-005 x_valid, x_insn[31:0], x_o_out[31:0], x_b_out[31:0], x_exception  in  XM-latch inputs from execute (valid, insn, ALU/jal/setx result, store data, write_exception).
REQ-006 wm_bypass_B  in  1, data_writeReg  in  32  writeback-to-memory bypass for store data.
REQ-007 stall_out  out  1  freezes execute and upstream stages.
REQ-008 o_xm_out  out  32  latched x_o_out, feeds the execute MX bypass.
REQ-009 xm_insn  out  32  latched insn, for hazard detection.
REQ-010 dmem_req, dmem_we  out  1 each; dmem_addr  out  ADDR_W; dmem_wdata  out  32.
REQ-011 dmem_ack  in  1; dmem_rdata  in  32.
REQ-012 mw_valid, mw_insn[31:0], mw_o[31:0], mw_d[31:0], mw_exception  out  MW-latch outputs to writeback.

Function
REQ-013 XM latch SHALL capture x_* at the rising edge when stall_out=0 and hold otherwise.
REQ-014 lw = opcode 01000, sw = opcode 00111 (insn[31:27]); a valid latched lw/sw is a mem-op.
REQ-015 FSM states: IDLE, WAIT. IDLE -> WAIT when a mem-op is latched and dmem_ack=0; WAIT -> IDLE on dmem_ack or on timeout.
REQ-016 dmem_req SHALL be 1 combinationally whenever a mem-op is latched and not yet completed; dmem_we=1 only for sw.
REQ-017 dmem_addr = xm_o[ADDR_W-1:0]; dmem_wdata = data_writeReg if wm_bypass_B else the latched b_out.
REQ-018 stall_out = dmem_req & ~dmem_ack & ~timeout; a zero-wait ack therefore adds no stall cycle.
REQ-019 Non-mem-op instructions SHALL pass from XM to MW in exactly one cycle.
REQ-020 MW latch updates every edge: on completion, it takes the XM contents plus mw_d=dmem_rdata (lw) or 0; while stalled, it receives a bubble (mw_valid=0, mw_insn=0).
REQ-021 Wait counter (4 bits) increments on each cycle in WAIT without ack and clears on leaving WAIT; timeout = counter==DMEM_TIMEOUT.
REQ-022 On timeout, the mem-op completes with mw_d=0 and dmem_req drops; ack and timeout in the same cycle count as ack.
REQ-023 An invalid latched instruction SHALL never raise dmem_req.

Reset
REQ-024 With reset low: state IDLE, counter 0, XM and MW latches 0, and all outputs 0 (stall_out=0, dmem_req=0).
REQ-025 A reset mid-WAIT SHALL abandon the request with no completion to MW.

Configuration
REQ-026 Macro XM_EXCEPTION_EN defined: mw_exception = latched x_exception, OR 1 with mw_o=32'd6 on timeout abort.
REQ-027 Macro undefined: mw_exception tied 0; a timeout still completes per REQ-022 and mw_o is unmodified.

Structure
REQ-028 Package pipeline_pkg SHALL hold the opcode constants (OP_LW, OP_SW), the exception code EXC_DMEM_TIMEOUT=6, and the FSM state enum.
REQ-029 Sub-module pipe_latch (width parameter, enable, clear) SHALL implement both the XM and MW latches.

Verification
REQ-030 add result 0x0000_0005 is latched -> o_xm_out=5 next cycle, MW holds it the cycle after, stall_out never 1.
REQ-031 lw with o_out=0x104 and ack after 3 cycles -> dmem_addr=0x104, stall_out high for 3 cycles, mw_d=dmem_rdata, with bubbles on MW meanwhile.
REQ-032 sw with wm_bypass_B=1, data_writeReg=0xDEADBEEF, zero-wait ack -> dmem_we=1, dmem_wdata=0xDEADBEEF, no stall.
REQ-033 lw with no ack -> exactly 15 stall cycles, then completion; with XM_EXCEPTION_EN, mw_exception=1 and mw_o=6.
REQ-034 Reset asserted during WAIT -> dmem_req=0 and mw_valid=0 immediately; after release, a fresh add flows normally.
